// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//   Multi-cycle MULT/MULTU/DIV/DIVU sequencer that sits beside the Execute
//   stage. It produces a 64-bit HI/LO result and raises a stall request while
//   a dependent instruction waits in Decode.
//
//   A multiply latches the full product in IDLE and then waits MUL_LATENCY
//   cycles. A divide runs a 32-step restoring divider on operand magnitudes,
//   followed by one sign-fix cycle.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start_mult        one-cycle MULT/MULTU issue pulse (honoured only in IDLE)
//   start_div         one-cycle DIV/DIVU issue pulse (honoured only in IDLE)
//   unsigned_op       1 = MULTU/DIVU, 0 = signed
//   op_a, op_b        rs / rt operands
//   hilo_read_d       D-stage instruction is MFHI/MFLO
//   muldiv_d          D-stage instruction is MULT/DIV/MTHI/MTLO
//   busy              sequencer is not IDLE
//   stall_req         busy & (hilo_read_d | muldiv_d)
//   hilo_write        one-cycle strobe (WB state)
//   hi_result         product[63:32] or remainder; held between WBs
//   lo_result         product[31:0] or quotient; held between WBs
//   div_by_zero       divide with op_b == 0, coincident with hilo_write
//   dbg_state         current FSM state (IDLE=0 MUL=1 DIV=2 SIGN=3 WB=4)
//
// Handshake: a start pulse is taken only when busy is low. hilo_write is a
// single-cycle qualifier for hi_result/lo_result, and there is no backpressure.
// -----------------------------------------------------------------------------
module muldiv_seq #(
  parameter int MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic        unsigned_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hilo_read_d,
  input  logic        muldiv_d,
  output logic        busy,
  output logic        stall_req,
  output logic        hilo_write,
  output logic [31:0] hi_result,
  output logic [31:0] lo_result,
  output logic        div_by_zero,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_SIGN = 3'd3,
    S_WB   = 3'd4
  } state_t;

  localparam logic [4:0] CNT_MUL = 5'(MUL_LATENCY - 1);
  localparam logic [4:0] CNT_DIV = 5'd31;

  state_t      r_state;
  state_t      w_next;

  logic [4:0]  r_cnt;
  logic [63:0] r_prod;
  logic [31:0] r_dvd;      // dividend magnitude, shifts left into the quotient
  logic [31:0] r_dvs;      // divisor magnitude
  logic [31:0] r_rem;      // partial remainder
  logic [31:0] r_orig_a;   // unmodified op_a, returned as HI on divide by zero
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dz;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_sext_a;
  logic        w_sext_b;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_diff;

  // Signed operands are sign-extended to 64 bits, so one 64x64 multiply
  // (low half kept) gives the correct product for both signed and unsigned.
  assign w_sext_a = ~unsigned_op & op_a[31];
  assign w_sext_b = ~unsigned_op & op_b[31];
  assign w_a_ext  = {{32{w_sext_a}}, op_a};
  assign w_b_ext  = {{32{w_sext_b}}, op_b};
  assign w_prod   = w_a_ext * w_b_ext;
  assign w_abs_a  = w_sext_a ? (32'd0 - op_a) : op_a;
  assign w_abs_b  = w_sext_b ? (32'd0 - op_b) : op_b;

  // Trial subtract. The partial remainder is always below the divisor, so
  // bit 32 of the difference is set exactly when the subtract would go negative.
  assign w_diff   = {r_rem, r_dvd[31]} - {1'b0, r_dvs};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; mult wins if both starts arrive together
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_mult)     w_next = S_MUL;
        else if (start_div) w_next = S_DIV;
      end
      S_MUL:   if (r_cnt == 5'd0) w_next = S_WB;
      S_DIV:   if (r_cnt == 5'd0) w_next = S_SIGN;
      S_SIGN:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath. The HI/LO result registers load on the transition into WB,
  // so they are stable during the hilo_write strobe and hold afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 5'd0;
      r_prod   <= 64'd0;
      r_dvd    <= 32'd0;
      r_dvs    <= 32'd0;
      r_rem    <= 32'd0;
      r_orig_a <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_mult) begin
            r_prod <= w_prod;
            r_cnt  <= CNT_MUL;
            r_dz   <= 1'b0;
          end else if (start_div) begin
            r_dvd    <= w_abs_a;
            r_dvs    <= w_abs_b;
            r_rem    <= 32'd0;
            r_cnt    <= CNT_DIV;
            r_orig_a <= op_a;
            r_neg_q  <= w_sext_a ^ w_sext_b;
            r_neg_r  <= w_sext_a;
            r_dz     <= (op_b == 32'd0);
          end
        end
        S_MUL: begin
          if (r_cnt == 5'd0) begin
            r_hi <= r_prod[63:32];
            r_lo <= r_prod[31:0];
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        S_DIV: begin
          r_rem <= w_diff[32] ? {r_rem[30:0], r_dvd[31]} : w_diff[31:0];
          r_dvd <= {r_dvd[30:0], ~w_diff[32]};
          if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
        end
        S_SIGN: begin
          if (r_dz) begin
            r_hi <= r_orig_a;
            r_lo <= 32'hFFFF_FFFF;
          end else begin
            r_hi <= r_neg_r ? (32'd0 - r_rem) : r_rem;
            r_lo <= r_neg_q ? (32'd0 - r_dvd) : r_dvd;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign stall_req   = busy & (hilo_read_d | muldiv_d);
  assign hilo_write  = (r_state == S_WB);
  assign div_by_zero = (r_state == S_WB) & r_dz;
  assign hi_result   = r_hi;
  assign lo_result   = r_lo;
  assign dbg_state   = r_state;

endmodule
